// File: rtl/dcpu16_pkg.sv
// Shared types and constants for the DCPU16 memory-bus arbiter.
// Holds the arbiter state encoding, master indices and round-robin helpers.
package dcpu16_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_F  = 2'd1,
      GNT_AB = 2'd2,
      GNT_W  = 2'd3
   } state_t;

   localparam logic [1:0] M_F  = 2'd0;
   localparam logic [1:0] M_AB = 2'd1;
   localparam logic [1:0] M_W  = 2'd2;

   localparam int TMO_DEFAULT = 15;

   // Next master in the F -> AB -> W -> F ring; an illegal index restarts at F.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         M_F:     nxt = M_AB;
         M_AB:    nxt = M_W;
         default: nxt = M_F;
      endcase
      return nxt;
   endfunction

   function automatic state_t gnt_state(input logic [1:0] idx);
      state_t st;
      case (idx)
         M_F:     st = GNT_F;
         M_AB:    st = GNT_AB;
         default: st = GNT_W;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/dcpu16_rr_pick.sv
// Combinational 3-way round-robin picker.
// Searches the ring starting at the master after 'last' and reports the first requester.
module dcpu16_rr_pick
   import dcpu16_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] gnt_idx,
   output logic       any
);

   logic [1:0] w_first;
   logic [1:0] w_second;
   logic [1:0] w_third;

   assign w_first  = rr_next(last);
   assign w_second = rr_next(w_first);
   assign w_third  = rr_next(w_second);

   // Priority search in ring order; 'last' itself is considered last.
   always_comb begin
      gnt_idx = M_F;
      any     = 1'b0;
      if (req[w_first]) begin
         gnt_idx = w_first;
         any     = 1'b1;
      end else if (req[w_second]) begin
         gnt_idx = w_second;
         any     = 1'b1;
      end else if (req[w_third]) begin
         gnt_idx = w_third;
         any     = 1'b1;
      end else begin
         gnt_idx = M_F;
         any     = 1'b0;
      end
   end

endmodule

// File: rtl/dcpu16_mbus_arb.sv
// Round-robin arbiter sharing one simplified-Wishbone memory port between the
// DCPU16 fetch, operand-load and write-back bus masters, with a bounded-wait timeout.
module dcpu16_mbus_arb
   import dcpu16_pkg::*;
#(
   parameter int AW  = 16,
   parameter int DW  = 16,
   parameter int TMO = TMO_DEFAULT
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] f_adr,
   input  logic          f_stb,
   output logic          f_ack,
   output logic          f_err,
   input  logic [AW-1:0] ab_adr,
   input  logic          ab_stb,
   output logic          ab_ack,
   output logic          ab_err,
   input  logic [AW-1:0] w_adr,
   input  logic          w_stb,
   input  logic          w_wre,
   input  logic [DW-1:0] w_dto,
   output logic          w_ack,
   output logic          w_err,
   output logic [DW-1:0] dti,
   output logic [AW-1:0] mem_adr,
   output logic          mem_stb,
   output logic          mem_wre,
   output logic [DW-1:0] mem_dto,
   input  logic [DW-1:0] mem_dti,
   input  logic          mem_ack,
   output logic          busy
);

   // A zero timeout still needs a one-bit counter so the declarations stay legal.
   localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = (TMO > 0) ? TW'(TMO - 1) : '0;
   localparam logic [TW-1:0] TMO_SAT  = (TMO > 0) ? TW'(TMO) : '0;

   state_t        r_state;
   logic [1:0]    r_last;
   logic [TW-1:0] r_tmo_cnt;
   logic [AW-1:0] r_mem_adr;
   logic          r_mem_stb;
   logic          r_mem_wre;
   logic [DW-1:0] r_mem_dto;

   logic [2:0]    w_req;
   logic [1:0]    w_pick_idx;
   logic          w_pick_any;
   logic          w_own_stb;
   logic          w_tmo_hit;
   logic          w_done;
   logic [AW-1:0] w_sel_adr;
   logic          w_sel_wre;
   logic [DW-1:0] w_sel_dto;

   assign w_req = {w_stb, ab_stb, f_stb};

   dcpu16_rr_pick u_pick (
      .req     (w_req),
      .last    (r_last),
      .gnt_idx (w_pick_idx),
      .any     (w_pick_any)
   );

   // Request line of whichever master currently owns the port.
   always_comb begin
      case (r_state)
         GNT_F:   w_own_stb = f_stb;
         GNT_AB:  w_own_stb = ab_stb;
         GNT_W:   w_own_stb = w_stb;
         default: w_own_stb = 1'b0;
      endcase
   end

   // Address/data of the master about to be granted; reads always carry zero data.
   always_comb begin
      case (w_pick_idx)
         M_F: begin
            w_sel_adr = f_adr;
            w_sel_wre = 1'b0;
            w_sel_dto = '0;
         end
         M_AB: begin
            w_sel_adr = ab_adr;
            w_sel_wre = 1'b0;
            w_sel_dto = '0;
         end
         default: begin
            w_sel_adr = w_adr;
            w_sel_wre = w_wre;
            w_sel_dto = w_wre ? w_dto : '0;
         end
      endcase
   end

   // An ack arriving in the expiry cycle wins over the timeout.
   assign w_tmo_hit = (TMO > 0) && (r_tmo_cnt == TMO_LAST) && !mem_ack;
   assign w_done    = mem_ack || !w_own_stb || w_tmo_hit;

   assign f_ack  = mem_ack && (r_state == GNT_F)  && f_stb;
   assign ab_ack = mem_ack && (r_state == GNT_AB) && ab_stb;
   assign w_ack  = mem_ack && (r_state == GNT_W)  && w_stb;

   assign f_err  = w_tmo_hit && (r_state == GNT_F)  && f_stb;
   assign ab_err = w_tmo_hit && (r_state == GNT_AB) && ab_stb;
   assign w_err  = w_tmo_hit && (r_state == GNT_W)  && w_stb;

   assign dti     = mem_dti;
   assign mem_adr = r_mem_adr;
   assign mem_stb = r_mem_stb;
   assign mem_wre = r_mem_wre;
   assign mem_dto = r_mem_dto;
   assign busy    = (r_state != IDLE);

   // Arbitration FSM: one transaction per grant, memory outputs frozen while granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last    <= M_W;
         r_tmo_cnt <= '0;
         r_mem_adr <= '0;
         r_mem_stb <= 1'b0;
         r_mem_wre <= 1'b0;
         r_mem_dto <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tmo_cnt <= '0;
               if (w_pick_any) begin
                  r_state   <= gnt_state(w_pick_idx);
                  r_last    <= w_pick_idx;
                  r_mem_adr <= w_sel_adr;
                  r_mem_wre <= w_sel_wre;
                  r_mem_dto <= w_sel_dto;
                  r_mem_stb <= 1'b1;
               end else begin
                  r_state   <= IDLE;
                  r_mem_stb <= 1'b0;
               end
            end
            GNT_F, GNT_AB, GNT_W: begin
               if (w_done) begin
                  r_state   <= IDLE;
                  r_mem_stb <= 1'b0;
                  r_mem_wre <= 1'b0;
                  r_tmo_cnt <= '0;
               end else if (r_tmo_cnt != TMO_SAT) begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
               end else begin
                  r_tmo_cnt <= r_tmo_cnt;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_mem_stb <= 1'b0;
               r_mem_wre <= 1'b0;
               r_tmo_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// Self-checking bench for dcpu16_mbus_arb: vector table of single transfers plus
// hand-written contention, timeout, reset and withdrawal sequences, with a grant scoreboard.
module tb_dcpu16_mbus_arb;
   import dcpu16_pkg::*;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int TMO = 15;
   localparam int NEVER = 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] f_adr = '0;
   logic          f_stb = 1'b0;
   logic          f_ack, f_err;
   logic [AW-1:0] ab_adr = '0;
   logic          ab_stb = 1'b0;
   logic          ab_ack, ab_err;
   logic [AW-1:0] w_adr = '0;
   logic          w_stb = 1'b0;
   logic          w_wre = 1'b0;
   logic [DW-1:0] w_dto = '0;
   logic          w_ack, w_err;
   logic [DW-1:0] dti;
   logic [AW-1:0] mem_adr;
   logic          mem_stb, mem_wre;
   logic [DW-1:0] mem_dto;
   logic [DW-1:0] mem_dti = '0;
   logic          mem_ack;
   logic          busy;

   dcpu16_mbus_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
      .clk(clk), .rst(rst),
      .f_adr(f_adr), .f_stb(f_stb), .f_ack(f_ack), .f_err(f_err),
      .ab_adr(ab_adr), .ab_stb(ab_stb), .ab_ack(ab_ack), .ab_err(ab_err),
      .w_adr(w_adr), .w_stb(w_stb), .w_wre(w_wre), .w_dto(w_dto),
      .w_ack(w_ack), .w_err(w_err), .dti(dti),
      .mem_adr(mem_adr), .mem_stb(mem_stb), .mem_wre(mem_wre), .mem_dto(mem_dto),
      .mem_dti(mem_dti), .mem_ack(mem_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   // Slave: acks once mem_stb has been high for slv_delay earlier cycles.
   int         slv_delay = NEVER;
   logic [7:0] slv_cnt = 8'd0;
   always @(posedge clk) begin
      if (mem_stb !== 1'b1 || mem_ack === 1'b1) slv_cnt <= 8'd0;
      else slv_cnt <= slv_cnt + 8'd1;
   end
   assign mem_ack = (mem_stb === 1'b1) && (int'(slv_cnt) == slv_delay);

   typedef struct {
      logic [1:0]    idx;
      logic [AW-1:0] adr;
      logic          wre;
      logic [DW-1:0] dto;
   } grant_t;

   typedef struct {
      logic [1:0]    idx;
      logic [AW-1:0] adr;
      logic          wre;
      logic [DW-1:0] dto;
      logic [DW-1:0] rdata;
      int            delay;
      logic          exp_err;
      int            exp_cyc;
   } vec_t;

   grant_t exp_q[$];
   grant_t cur;
   int     checks = 0;
   int     failures = 0;
   logic   prev_stb = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] idx, input logic [AW-1:0] adr,
                       input logic wre, input logic [DW-1:0] dto);
      grant_t g;
      g.idx = idx;
      g.adr = adr;
      g.wre = wre;
      g.dto = dto;
      exp_q.push_back(g);
   endtask

   task automatic set_req(input logic [1:0] idx, input logic s, input logic [AW-1:0] adr,
                          input logic wre, input logic [DW-1:0] dto);
      case (idx)
         M_F:  begin f_stb = s; f_adr = adr; end
         M_AB: begin ab_stb = s; ab_adr = adr; end
         default: begin w_stb = s; w_adr = adr; w_wre = wre; w_dto = dto; end
      endcase
   endtask

   function automatic logic ack_of(input logic [1:0] idx);
      case (idx)
         M_F:     return f_ack;
         M_AB:    return ab_ack;
         default: return w_ack;
      endcase
   endfunction

   function automatic logic err_of(input logic [1:0] idx);
      case (idx)
         M_F:     return f_err;
         M_AB:    return ab_err;
         default: return w_err;
      endcase
   endfunction

   // Monitor: pops the scoreboard on each new grant and checks per-cycle invariants.
   always @(posedge clk) begin
      #3;
      if (rst === 1'b0) begin
         if (mem_stb === 1'b1 && prev_stb !== 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_grant actual_adr=%h required=none", mem_adr);
            end else begin
               cur = exp_q.pop_front();
               chk("grant_adr", 32'(mem_adr), 32'(cur.adr));
               chk("grant_wre", 32'(mem_wre), 32'(cur.wre));
               chk("grant_dto", 32'(mem_dto), 32'(cur.dto));
            end
         end else if (mem_stb === 1'b1) begin
            chk("hold_adr", 32'(mem_adr), 32'(cur.adr));
            chk("hold_wre", 32'(mem_wre), 32'(cur.wre));
            chk("hold_dto", 32'(mem_dto), 32'(cur.dto));
         end
         chk("ack_onehot", 32'($onehot0({f_ack, ab_ack, w_ack})), 32'd1);
         chk("ack_err_excl", 32'((f_ack | ab_ack | w_ack) & (f_err | ab_err | w_err)), 32'd0);
         chk("busy_vs_stb", 32'(busy), 32'(mem_stb));
         if (f_ack === 1'b1)  chk("f_ack_owner", 32'(cur.idx), 32'(M_F));
         if (ab_ack === 1'b1) chk("ab_ack_owner", 32'(cur.idx), 32'(M_AB));
         if (w_ack === 1'b1)  chk("w_ack_owner", 32'(cur.idx), 32'(M_W));
      end
      prev_stb = mem_stb;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   vec_t vecs[7];
   int   cyc, n, errcyc;
   logic got_ack, got_err;
   logic [DW-1:0] rd;

   initial begin
      vecs[0] = '{M_F,  16'h0040, 1'b0, 16'h0000, 16'h7C01, 1,     1'b0, 2};
      vecs[1] = '{M_AB, 16'h0123, 1'b0, 16'h0000, 16'h1357, 0,     1'b0, 1};
      vecs[2] = '{M_W,  16'h1000, 1'b1, 16'hBEEF, 16'h0000, 4,     1'b0, 5};
      vecs[3] = '{M_W,  16'h2222, 1'b0, 16'hABCD, 16'h5A5A, 2,     1'b0, 3};
      vecs[4] = '{M_AB, 16'h0456, 1'b0, 16'h0000, 16'h0000, NEVER, 1'b1, 15};
      vecs[5] = '{M_F,  16'h0789, 1'b0, 16'h0000, 16'hC0DE, 14,    1'b0, 15};
      vecs[6] = '{M_W,  16'h3FFE, 1'b1, 16'h0F0F, 16'h0000, 13,    1'b0, 14};

      // Reset state
      step();
      step();
      chk("rst_mem_stb", 32'(mem_stb), 32'd0);
      chk("rst_mem_wre", 32'(mem_wre), 32'd0);
      chk("rst_mem_adr", 32'(mem_adr), 32'd0);
      chk("rst_mem_dto", 32'(mem_dto), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_acks", 32'({f_ack, ab_ack, w_ack, f_err, ab_err, w_err}), 32'd0);
      rst = 1'b0;
      step();

      // Single-master vectors
      for (int i = 0; i < 7; i++) begin
         slv_delay = vecs[i].delay;
         mem_dti   = vecs[i].rdata;
         push(vecs[i].idx, vecs[i].adr,
              (vecs[i].idx == M_W) ? vecs[i].wre : 1'b0,
              (vecs[i].idx == M_W && vecs[i].wre) ? vecs[i].dto : 16'h0000);
         set_req(vecs[i].idx, 1'b1, vecs[i].adr, vecs[i].wre, vecs[i].dto);
         got_ack = 1'b0;
         got_err = 1'b0;
         cyc = 0;
         rd = '0;
         for (int c = 1; c <= 40; c++) begin
            step();
            if (ack_of(vecs[i].idx) === 1'b1 || err_of(vecs[i].idx) === 1'b1) begin
               cyc = c;
               got_ack = ack_of(vecs[i].idx);
               got_err = err_of(vecs[i].idx);
               rd = dti;
               break;
            end
         end
         chk($sformatf("vec%0d_ack", i), 32'(got_ack), 32'(!vecs[i].exp_err));
         chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         if (!vecs[i].exp_err) chk($sformatf("vec%0d_dti", i), 32'(rd), 32'(vecs[i].rdata));
         step();
         chk($sformatf("vec%0d_stb_low", i), 32'(mem_stb), 32'd0);
         chk($sformatf("vec%0d_no_err_after", i), 32'(err_of(vecs[i].idx)), 32'd0);
         set_req(vecs[i].idx, 1'b0, vecs[i].adr, 1'b0, 16'h0000);
         step();
      end

      // Three-way contention straight out of reset: F, AB, W, then F again
      rst = 1'b1;
      step();
      step();
      slv_delay = 0;
      push(M_F, 16'h0100, 1'b0, 16'h0000);
      push(M_AB, 16'h0200, 1'b0, 16'h0000);
      push(M_W, 16'h0300, 1'b1, 16'h1111);
      push(M_F, 16'h0100, 1'b0, 16'h0000);
      push(M_AB, 16'h0200, 1'b0, 16'h0000);
      push(M_W, 16'h0300, 1'b1, 16'h1111);
      rst = 1'b0;
      set_req(M_F, 1'b1, 16'h0100, 1'b0, 16'h0000);
      set_req(M_AB, 1'b1, 16'h0200, 1'b0, 16'h0000);
      set_req(M_W, 1'b1, 16'h0300, 1'b1, 16'h1111);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if ((f_ack | ab_ack | w_ack) === 1'b1) n++;
         if (n == 6) break;
      end
      step();
      f_stb = 1'b0;
      ab_stb = 1'b0;
      w_stb = 1'b0;
      step();
      step();
      chk("contention_acks", 32'(n), 32'd6);
      chk("contention_q_empty", 32'(exp_q.size()), 32'd0);

      // Timeout on AB with a pending fetch served afterwards
      slv_delay = NEVER;
      push(M_AB, 16'h0AB0, 1'b0, 16'h0000);
      push(M_F, 16'h0F00, 1'b0, 16'h0000);
      set_req(M_AB, 1'b1, 16'h0AB0, 1'b0, 16'h0000);
      step();
      step();
      set_req(M_F, 1'b1, 16'h0F00, 1'b0, 16'h0000);
      errcyc = 0;
      for (int c = 3; c <= 40; c++) begin
         step();
         if (ab_err === 1'b1 || ab_ack === 1'b1) begin
            errcyc = (ab_err === 1'b1) ? c : -c;
            break;
         end
      end
      chk("tmo_err_cycle", 32'(errcyc), 32'd15);
      step();
      chk("tmo_err_once", 32'(ab_err), 32'd0);
      chk("tmo_stb_low", 32'(mem_stb), 32'd0);
      slv_delay = 0;
      mem_dti = 16'h4242;
      ab_stb = 1'b0;
      step();
      chk("tmo_f_ack", 32'(f_ack), 32'd1);
      chk("tmo_f_dti", 32'(dti), 32'h4242);
      step();
      f_stb = 1'b0;
      step();

      // Reset in the middle of a write-back grant
      slv_delay = NEVER;
      push(M_W, 16'h3000, 1'b1, 16'h1234);
      set_req(M_W, 1'b1, 16'h3000, 1'b1, 16'h1234);
      step();
      step();
      step();
      chk("rstw_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      set_req(M_F, 1'b1, 16'h0F10, 1'b0, 16'h0000);
      step();
      chk("rstw_mem_stb", 32'(mem_stb), 32'd0);
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_mem_adr", 32'(mem_adr), 32'd0);
      chk("rstw_no_ack_err", 32'({w_ack, w_err}), 32'd0);
      rst = 1'b0;
      slv_delay = 0;
      push(M_F, 16'h0F10, 1'b0, 16'h0000);
      push(M_W, 16'h3000, 1'b1, 16'h1234);
      n = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if ((f_ack | ab_ack | w_ack) === 1'b1) n++;
         if (n == 2) break;
      end
      step();
      f_stb = 1'b0;
      w_stb = 1'b0;
      step();
      step();
      chk("rstw_acks", 32'(n), 32'd2);
      chk("rstw_q_empty", 32'(exp_q.size()), 32'd0);

      // Early withdrawal by F, queued AB granted afterwards
      slv_delay = NEVER;
      push(M_F, 16'h0F20, 1'b0, 16'h0000);
      push(M_AB, 16'h0AB1, 1'b0, 16'h0000);
      set_req(M_F, 1'b1, 16'h0F20, 1'b0, 16'h0000);
      set_req(M_AB, 1'b1, 16'h0AB1, 1'b0, 16'h0000);
      step();
      chk("wd_c1_f", 32'({f_ack, f_err}), 32'd0);
      chk("wd_c1_busy", 32'(busy), 32'd1);
      step();
      f_stb = 1'b0;
      step();
      chk("wd_c3_stb", 32'(mem_stb), 32'd0);
      chk("wd_c3_f", 32'({f_ack, f_err}), 32'd0);
      slv_delay = 0;
      step();
      chk("wd_ab_ack", 32'(ab_ack), 32'd1);
      step();
      ab_stb = 1'b0;
      step();
      step();
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
